decode_hazard_unit: RTL and testbench
=====================================

DECODE_HAZARD_UNIT -- requirements
Module: decode_hazard_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-002 The block SHALL have parameter AREG_W, default 5, meaning the register-address width (2**AREG_W registers).
REQ-003 The block SHALL have parameter NSTG, default 3, meaning the number of downstream stages checked (index 0 = youngest/ALU).
REQ-004 The block SHALL have parameter FWD_EN, default 1, meaning 1 = forward results, 0 = stall-only (interlock) mode.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, the reset: asynchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1, the fetch instruction-valid flag.
REQ-008 The block SHALL have port in_insn, input, 32, the fetched instruction.
REQ-009 The block SHALL have port in_pc, input, 32, the fetched PC.
REQ-010 The block SHALL have port in_ready, output, 1, which is high when the fetch word is accepted this cycle.
REQ-011 The block SHALL have port rf_rs_addr, output, AREG_W, the register-file read address for rs.
REQ-012 The block SHALL have port rf_rt_addr, output, AREG_W, the register-file read address for rt.
REQ-013 The block SHALL have port rf_rs_data, input, DATA_W, the combinational register-file read data for rs.
REQ-014 The block SHALL have port rf_rt_data, input, DATA_W, the combinational register-file read data for rt.
REQ-015 The block SHALL have port stg_we, input, NSTG, the per-stage register-write-enable flags.
REQ-016 The block SHALL have port stg_load, input, NSTG, the per-stage flag for a load whose data is not yet available.
REQ-017 The block SHALL have port stg_rd, input, NSTG*AREG_W, the per-stage destination registers.
REQ-018 The block SHALL have port stg_data, input, NSTG*DATA_W, the per-stage result data.
REQ-019 The block SHALL have port flush, input, 1, the taken-branch squash signal.
REQ-020 The block SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-021 The block SHALL have port out_valid, output, 1, the decoded-bundle valid flag.
REQ-022 The block SHALL have ports out_insn and out_pc, output, 32 each, the registered instruction and PC.
REQ-023 The block SHALL have ports out_rs_data and out_rt_data, output, DATA_W each, the resolved operands.
REQ-024 The block SHALL have port out_rd, output, AREG_W, the destination register (rd, rt, or 31 for JAL).
REQ-025 The block SHALL have port out_ctrl, output, 8, the control vector {REG_WE, I_TYPE, R_TYPE, J_TYPE, MEM_WE, MEM_WB, MEM_READ, LINK}.
REQ-026 The block SHALL have port stall_cnt, output, 16, a saturating counter of hazard-stall cycles.

Function
REQ-027 The block SHALL hold the current instruction in a one-entry hold register, valid flag hv; in_ready SHALL equal !hv.
REQ-028 The block SHALL define the current instruction as the held word when hv=1, otherwise in_insn/in_pc qualified by in_valid.
REQ-029 The block SHALL decode source usage by opcode: R-type, BEQ, BNE and SW use rs and rt.
REQ-030 The block SHALL decode ADDIU, SLTI, ORI, LW, BGTZ, BLEZ and REGIMM as using rs only.
REQ-031 The block SHALL decode LUI, J and JAL as using no source.
REQ-032 The block SHALL treat an all-zero instruction as a NOP with no sources and an all-zero control vector.
REQ-033 The block SHALL generate out_ctrl and out_rd as follows: R-type except JR writes rd; I-type ALU ops and LW write rt; LW sets MEM_WB and MEM_READ; SW sets MEM_WE; JAL sets REG_WE and LINK with rd=31; branches and J set J_TYPE only.
REQ-034 The block SHALL record a match for stage i when a used source equals stg_rd[i], stg_we[i]=1 and the source register is not 0 (register 0 never matches).
REQ-035 In FWD_EN=0 mode, any match SHALL raise a hazard stall.
REQ-036 In FWD_EN=1 mode, a match SHALL raise a hazard stall only if the lowest-index matching stage has stg_load=1.
REQ-037 In FWD_EN=1 mode, operand data SHALL otherwise come from stg_data of the lowest-index matching stage, else from rf data.
REQ-038 The block SHALL load the output register when (out_ready or !out_valid) and no hazard stall and flush=0: out_valid<=1 with the current bundle; hv<=0.
REQ-039 On a hazard stall, out_valid SHALL go to 0 if out_ready=1 (bubble inserted), and the current instruction SHALL be captured or kept in the hold register with hv<=1.
REQ-040 When out_ready=0 and out_valid=1, all outputs SHALL hold and the current instruction SHALL be captured in the hold register.
REQ-041 flush SHALL have priority over every other event: out_valid<=0, hv<=0, in_ready=1 on the next cycle, and no stall count.
REQ-042 stall_cnt SHALL increment once per cycle of hazard stall without flush and saturate at 16'hFFFF.
REQ-043 Decode-to-output latency SHALL be 1 cycle without hazard, and a load-use hazard SHALL cost exactly 1 bubble when FWD_EN=1.

Reset
REQ-044 While reset=1, the block SHALL clear out_valid, hv, out_ctrl, out_rd, out_insn, out_pc, out_rs_data, out_rt_data and stall_cnt to 0 asynchronously.
REQ-045 A reset asserted mid-stall SHALL discard the held instruction, and in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-046 The opcode/funct constants and the control-bit indices SHALL reside in the shared control include, and the block SHALL NOT redefine them.
REQ-047 The forwarding/hazard comparator across NSTG stages SHALL be one sub-module, hazard_match, instantiated once per source operand.
REQ-048 The register file SHALL remain external and SHALL NOT be instantiated in this block.

Verification
REQ-049 ADDIU r2 in stage 0 with data 0x10, followed by ADDU r3,r2,r2 at FWD_EN=1, SHALL produce no stall and out_rs_data=out_rt_data=0x10.
REQ-050 LW r4 in stage 0 with stg_load=1, followed by SW r4, SHALL produce 1 bubble (out_valid=0 for one cycle), stall_cnt=1, then forwarded data.
REQ-051 A write to r0 in stage 0, followed by an instruction reading r0, SHALL produce no stall and operand data from rf (0).
REQ-052 At FWD_EN=0, r5 matching stage 2 only SHALL stall until that match clears, then issue with rf data.
REQ-053 flush asserted while the block is held (hv=1, out_ready=0) SHALL give out_valid=0 and in_ready=1 next cycle, and the held instruction SHALL never appear.
REQ-054 Reset asserted during a stall SHALL clear all outputs to 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/decode_hazard_unit_pkg.sv
// Shared opcode/funct constants, control-vector bit positions and the
// instruction decoder used by the decode/hazard stage.
package decode_hazard_unit_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FN_JR     = 6'h08;

  localparam int CTRL_W      = 8;
  localparam int CB_REG_WE   = 7;
  localparam int CB_I_TYPE   = 6;
  localparam int CB_R_TYPE   = 5;
  localparam int CB_J_TYPE   = 4;
  localparam int CB_MEM_WE   = 3;
  localparam int CB_MEM_WB   = 2;
  localparam int CB_MEM_READ = 1;
  localparam int CB_LINK     = 0;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic              use_rs;
    logic              use_rt;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } dec_t;

  // An all-zero word is a NOP; unknown opcodes decode to nothing as well.
  function automatic dec_t decode_insn(input logic [31:0] insn);
    dec_t d;
    d = '0;
    if (insn != 32'h0) begin
      unique case (insn[31:26])
        OP_RTYPE: begin
          d.use_rs = 1'b1;
          d.use_rt = 1'b1;
          d.ctrl[CB_R_TYPE] = 1'b1;
          if (insn[5:0] != FN_JR) begin
            d.ctrl[CB_REG_WE] = 1'b1;
            d.rd = insn[15:11];
          end
        end
        OP_ADDIU, OP_SLTI, OP_ORI: begin
          d.use_rs = 1'b1;
          d.ctrl[CB_REG_WE] = 1'b1;
          d.ctrl[CB_I_TYPE] = 1'b1;
          d.rd = insn[20:16];
        end
        OP_LUI: begin
          d.ctrl[CB_REG_WE] = 1'b1;
          d.ctrl[CB_I_TYPE] = 1'b1;
          d.rd = insn[20:16];
        end
        OP_LW: begin
          d.use_rs = 1'b1;
          d.ctrl[CB_REG_WE]   = 1'b1;
          d.ctrl[CB_I_TYPE]   = 1'b1;
          d.ctrl[CB_MEM_WB]   = 1'b1;
          d.ctrl[CB_MEM_READ] = 1'b1;
          d.rd = insn[20:16];
        end
        OP_SW: begin
          d.use_rs = 1'b1;
          d.use_rt = 1'b1;
          d.ctrl[CB_I_TYPE] = 1'b1;
          d.ctrl[CB_MEM_WE] = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          d.use_rs = 1'b1;
          d.use_rt = 1'b1;
          d.ctrl[CB_J_TYPE] = 1'b1;
        end
        OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
          d.use_rs = 1'b1;
          d.ctrl[CB_J_TYPE] = 1'b1;
        end
        OP_J: d.ctrl[CB_J_TYPE] = 1'b1;
        OP_JAL: begin
          d.ctrl[CB_REG_WE] = 1'b1;
          d.ctrl[CB_LINK]   = 1'b1;
          d.rd = LINK_REG;
        end
        default: d = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_hazard_unit_hazard_match.sv
// Per-operand comparator against all downstream stages: reports a stall and
// selects forwarded data from the youngest (lowest-index) matching stage.
module hazard_match #(
  parameter int DATA_W = 32,
  parameter int AREG_W = 5,
  parameter int NSTG   = 3,
  parameter int FWD_EN = 1
) (
  input  logic [AREG_W-1:0]      src_i,
  input  logic                   used_i,
  input  logic [NSTG-1:0]        stg_we_i,
  input  logic [NSTG-1:0]        stg_load_i,
  input  logic [NSTG*AREG_W-1:0] stg_rd_i,
  input  logic [NSTG*DATA_W-1:0] stg_data_i,
  input  logic [DATA_W-1:0]      rf_data_i,
  output logic                   stall_o,
  output logic [DATA_W-1:0]      data_o
);

  logic [NSTG-1:0]   hit;
  logic              sel_load;
  logic [DATA_W-1:0] sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < NSTG; gi++) begin : g_stage
      assign hit[gi] = used_i && (src_i != '0) && stg_we_i[gi] &&
                       (stg_rd_i[gi*AREG_W +: AREG_W] == src_i);
    end
  endgenerate

  // Walk oldest to youngest so the lowest-index hit is the one that sticks.
  always_comb begin
    sel_load = 1'b0;
    sel_data = rf_data_i;
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_load = stg_load_i[i];
        sel_data = stg_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign stall_o = (FWD_EN != 0) ? ((|hit) && sel_load) : (|hit);
  assign data_o  = (FWD_EN != 0) ? sel_data : rf_data_i;

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode stage with a one-entry hold register, operand forwarding/interlock
// against NSTG downstream stages and a registered output bundle.
module decode_hazard_unit
  import decode_hazard_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AREG_W = 5,
  parameter int NSTG   = 3,
  parameter int FWD_EN = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [31:0]            in_insn,
  input  logic [31:0]            in_pc,
  output logic                   in_ready,
  output logic [AREG_W-1:0]      rf_rs_addr,
  output logic [AREG_W-1:0]      rf_rt_addr,
  input  logic [DATA_W-1:0]      rf_rs_data,
  input  logic [DATA_W-1:0]      rf_rt_data,
  input  logic [NSTG-1:0]        stg_we,
  input  logic [NSTG-1:0]        stg_load,
  input  logic [NSTG*AREG_W-1:0] stg_rd,
  input  logic [NSTG*DATA_W-1:0] stg_data,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            out_insn,
  output logic [31:0]            out_pc,
  output logic [DATA_W-1:0]      out_rs_data,
  output logic [DATA_W-1:0]      out_rt_data,
  output logic [AREG_W-1:0]      out_rd,
  output logic [7:0]             out_ctrl,
  output logic [15:0]            stall_cnt
);

  logic              hv_q, hv_d;
  logic [31:0]       hold_insn_q, hold_insn_d;
  logic [31:0]       hold_pc_q, hold_pc_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_insn_q, out_insn_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic [DATA_W-1:0] out_rs_q, out_rs_d;
  logic [DATA_W-1:0] out_rt_q, out_rt_d;
  logic [AREG_W-1:0] out_rd_q, out_rd_d;
  logic [7:0]        out_ctrl_q, out_ctrl_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic              cur_valid;
  logic [31:0]       cur_insn;
  logic [31:0]       cur_pc;
  dec_t              dec;
  logic              rs_stall, rt_stall, hazard;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  assign cur_valid  = hv_q | in_valid;
  assign cur_insn   = hv_q ? hold_insn_q : in_insn;
  assign cur_pc     = hv_q ? hold_pc_q : in_pc;
  assign dec        = decode_insn(cur_insn);
  assign rf_rs_addr = AREG_W'(cur_insn[25:21]);
  assign rf_rt_addr = AREG_W'(cur_insn[20:16]);

  hazard_match #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NSTG(NSTG), .FWD_EN(FWD_EN)) u_rs_match (
    .src_i(rf_rs_addr), .used_i(dec.use_rs), .stg_we_i(stg_we), .stg_load_i(stg_load),
    .stg_rd_i(stg_rd), .stg_data_i(stg_data), .rf_data_i(rf_rs_data),
    .stall_o(rs_stall), .data_o(rs_fwd)
  );

  hazard_match #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NSTG(NSTG), .FWD_EN(FWD_EN)) u_rt_match (
    .src_i(rf_rt_addr), .used_i(dec.use_rt), .stg_we_i(stg_we), .stg_load_i(stg_load),
    .stg_rd_i(stg_rd), .stg_data_i(stg_data), .rf_data_i(rf_rt_data),
    .stall_o(rt_stall), .data_o(rt_fwd)
  );

  assign hazard = cur_valid & (rs_stall | rt_stall);

  always_comb begin
    hv_d        = hv_q;
    hold_insn_d = hold_insn_q;
    hold_pc_d   = hold_pc_q;
    out_valid_d = out_valid_q;
    out_insn_d  = out_insn_q;
    out_pc_d    = out_pc_q;
    out_rs_d    = out_rs_q;
    out_rt_d    = out_rt_q;
    out_rd_d    = out_rd_q;
    out_ctrl_d  = out_ctrl_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
      hv_d        = 1'b0;
    end else if (hazard) begin
      // A consumed bundle is replaced by a bubble; a blocked one stays put.
      out_valid_d = out_valid_q & ~out_ready;
      hv_d        = 1'b1;
      hold_insn_d = cur_insn;
      hold_pc_d   = cur_pc;
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else if (out_ready || !out_valid_q) begin
      out_valid_d = cur_valid;
      hv_d        = 1'b0;
      if (cur_valid) begin
        out_insn_d = cur_insn;
        out_pc_d   = cur_pc;
        out_rs_d   = rs_fwd;
        out_rt_d   = rt_fwd;
        out_rd_d   = AREG_W'(dec.rd);
        out_ctrl_d = dec.ctrl;
      end
    end else if (cur_valid) begin
      hv_d        = 1'b1;
      hold_insn_d = cur_insn;
      hold_pc_d   = cur_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hv_q        <= 1'b0;
      hold_insn_q <= '0;
      hold_pc_q   <= '0;
      out_valid_q <= 1'b0;
      out_insn_q  <= '0;
      out_pc_q    <= '0;
      out_rs_q    <= '0;
      out_rt_q    <= '0;
      out_rd_q    <= '0;
      out_ctrl_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      hv_q        <= hv_d;
      hold_insn_q <= hold_insn_d;
      hold_pc_q   <= hold_pc_d;
      out_valid_q <= out_valid_d;
      out_insn_q  <= out_insn_d;
      out_pc_q    <= out_pc_d;
      out_rs_q    <= out_rs_d;
      out_rt_q    <= out_rt_d;
      out_rd_q    <= out_rd_d;
      out_ctrl_q  <= out_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready    = ~hv_q;
  assign out_valid   = out_valid_q;
  assign out_insn    = out_insn_q;
  assign out_pc      = out_pc_q;
  assign out_rs_data = out_rs_q;
  assign out_rt_data = out_rt_q;
  assign out_rd      = out_rd_q;
  assign out_ctrl    = out_ctrl_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed bench: forwarding instance checked through a scoreboard, plus an
// interlock-only instance checked directly in its own scenario.
module tb_decode_hazard_unit;

  localparam int DATA_W = 32;
  localparam int AREG_W = 5;
  localparam int NSTG   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                   in_valid, flush, out_ready;
  logic [31:0]            in_insn, in_pc;
  logic [NSTG-1:0]        stg_we, stg_load;
  logic [NSTG*AREG_W-1:0] stg_rd;
  logic [NSTG*DATA_W-1:0] stg_data;

  logic              in_ready, out_valid;
  logic [AREG_W-1:0] rf_rs_addr, rf_rt_addr, out_rd;
  logic [DATA_W-1:0] rf_rs_data, rf_rt_data, out_rs_data, out_rt_data;
  logic [31:0]       out_insn, out_pc;
  logic [7:0]        out_ctrl;
  logic [15:0]       stall_cnt;

  logic              f0_in_ready, f0_out_valid;
  logic [AREG_W-1:0] f0_rs_addr, f0_rt_addr, f0_out_rd;
  logic [DATA_W-1:0] f0_rs_data, f0_rt_data, f0_out_rs, f0_out_rt;
  logic [31:0]       f0_out_insn, f0_out_pc;
  logic [7:0]        f0_out_ctrl;
  logic [15:0]       f0_stall_cnt;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : (32'hA000_0000 | {27'h0, a});
  endfunction

  assign rf_rs_data = rf_val(rf_rs_addr);
  assign rf_rt_data = rf_val(rf_rt_addr);
  assign f0_rs_data = rf_val(f0_rs_addr);
  assign f0_rt_data = rf_val(f0_rt_addr);

  decode_hazard_unit #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NSTG(NSTG), .FWD_EN(1)) u_dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc),
    .in_ready(in_ready), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .stg_we(stg_we), .stg_load(stg_load),
    .stg_rd(stg_rd), .stg_data(stg_data), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc), .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data), .out_rd(out_rd), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  decode_hazard_unit #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NSTG(NSTG), .FWD_EN(0)) u_dut0 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc),
    .in_ready(f0_in_ready), .rf_rs_addr(f0_rs_addr), .rf_rt_addr(f0_rt_addr),
    .rf_rs_data(f0_rs_data), .rf_rt_data(f0_rt_data), .stg_we(stg_we), .stg_load(stg_load),
    .stg_rd(stg_rd), .stg_data(stg_data), .flush(flush), .out_ready(out_ready),
    .out_valid(f0_out_valid), .out_insn(f0_out_insn), .out_pc(f0_out_pc), .out_rs_data(f0_out_rs),
    .out_rt_data(f0_out_rt), .out_rd(f0_out_rd), .out_ctrl(f0_out_ctrl), .stall_cnt(f0_stall_cnt)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] I_ADDU_3_2_2  = 32'h0042_1821;
  localparam logic [31:0] I_ADDIU_7_0_5 = 32'h2407_0005;
  localparam logic [31:0] I_SW_4_1      = 32'hAC24_0000;
  localparam logic [31:0] I_JAL         = 32'h0C00_0040;
  localparam logic [31:0] I_ORI_9_0     = 32'h3409_00FF;
  localparam logic [31:0] I_ADDU_6_5_0  = 32'h00A0_3021;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_stg(input int i, input logic we, input logic ld,
                         input logic [4:0] rd, input logic [31:0] d);
    stg_we[i]                 = we;
    stg_load[i]               = ld;
    stg_rd[i*AREG_W +: AREG_W] = rd;
    stg_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clr_stg();
    stg_we = '0; stg_load = '0; stg_rd = '0; stg_data = '0;
  endtask

  task automatic push(input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] rd, input logic [7:0] ctrl);
    exp_t e;
    e.insn = insn; e.pc = pc; e.rs = rs; e.rt = rt; e.rd = rd; e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  // A bundle presented with out_ready high is consumed at the coming edge.
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed insn 0x%0h expected no output", out_insn);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn pc=0x%08h insn=0x%08h rs=0x%08h rt=0x%08h rd=%0d ctrl=0x%02h",
                 out_pc, out_insn, out_rs_data, out_rt_data, out_rd, out_ctrl);
        chk("out_insn", out_insn, e.insn);
        chk("out_pc", out_pc, e.pc);
        chk("out_rs_data", out_rs_data, e.rs);
        chk("out_rt_data", out_rt_data, e.rt);
        chk("out_rd", out_rd, e.rd);
        chk("out_ctrl", out_ctrl, e.ctrl);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_insn = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    clr_stg();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_insn", out_insn, 0);
    chk("rst_out_rs", out_rs_data, 0);
    reset = 1'b0;

    // ALU result in stage 0 forwarded to both operands, no stall.
    set_stg(0, 1'b1, 1'b0, 5'd2, 32'h10);
    in_valid = 1'b1; in_insn = I_ADDU_3_2_2; in_pc = 32'h100;
    chk("fwd_in_ready", in_ready, 1);
    push(I_ADDU_3_2_2, 32'h100, 32'h10, 32'h10, 5'd3, 8'hA0);
    tick();
    chk("fwd_latency_valid", out_valid, 1);
    chk("fwd_stall_cnt", stall_cnt, 0);

    // Write to r0 never matches; operands from the register file.
    set_stg(0, 1'b1, 1'b0, 5'd0, 32'h55);
    in_insn = I_ADDIU_7_0_5; in_pc = 32'h104;
    push(I_ADDIU_7_0_5, 32'h104, 32'h0, rf_val(5'd7), 5'd7, 8'hC0);
    tick();
    chk("r0_valid", out_valid, 1);
    chk("r0_stall_cnt", stall_cnt, 0);

    // Load-use: one bubble, then forwarded load data.
    set_stg(0, 1'b1, 1'b1, 5'd4, 32'h0);
    in_insn = I_SW_4_1; in_pc = 32'h108;
    push(I_SW_4_1, 32'h108, rf_val(5'd1), 32'hDEAD_BEEF, 5'd0, 8'h48);
    tick();
    chk("lu_bubble", out_valid, 0);
    chk("lu_in_ready", in_ready, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    in_valid = 1'b0;
    clr_stg();
    set_stg(1, 1'b1, 1'b0, 5'd4, 32'hDEAD_BEEF);
    tick();
    chk("lu_issue_valid", out_valid, 1);
    chk("lu_issue_in_ready", in_ready, 1);
    chk("lu_stall_cnt_after", stall_cnt, 1);

    // JAL links to r31.
    clr_stg();
    in_valid = 1'b1; in_insn = I_JAL; in_pc = 32'h10C;
    push(I_JAL, 32'h10C, 32'h0, 32'h0, 5'd31, 8'h81);
    tick();
    chk("jal_valid", out_valid, 1);

    // Backpressure then flush while held: neither bundle may ever emerge.
    in_insn = I_ADDU_3_2_2; in_pc = 32'h110;
    tick();
    out_ready = 1'b0;
    in_insn = I_ORI_9_0; in_pc = 32'h114;
    tick();
    chk("bp_valid_hold", out_valid, 1);
    chk("bp_insn_hold", out_insn, I_ADDU_3_2_2);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    chk("bp_pc_hold", out_pc, 32'h110);
    flush = 1'b1;
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush_no_reappear", out_valid, 0);

    // Flush coincident with a hazard: no stall is counted.
    set_stg(0, 1'b1, 1'b1, 5'd4, 32'h0);
    in_valid = 1'b1; in_insn = I_SW_4_1; in_pc = 32'h120; flush = 1'b1;
    tick();
    chk("fh_stall_cnt", stall_cnt, 1);
    chk("fh_valid", out_valid, 0);
    chk("fh_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0;
    clr_stg();

    // Reset mid-stall clears everything without a clock edge.
    in_valid = 1'b1; in_insn = I_ADDU_3_2_2; in_pc = 32'h130;
    tick();
    out_ready = 1'b0;
    set_stg(0, 1'b1, 1'b1, 5'd4, 32'h0);
    in_insn = I_SW_4_1; in_pc = 32'h134;
    tick();
    chk("rs_pre_valid", out_valid, 1);
    chk("rs_pre_in_ready", in_ready, 0);
    chk("rs_pre_stall_cnt", stall_cnt, 2);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_insn", out_insn, 0);
    chk("async_pc", out_pc, 0);
    chk("async_ctrl", out_ctrl, 0);
    chk("async_rd", out_rd, 0);
    chk("async_rs", out_rs_data, 0);
    chk("async_rt", out_rt_data, 0);
    chk("async_stall_cnt", stall_cnt, 0);
    #2;
    reset = 1'b0;
    clr_stg();
    out_ready = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (2) tick();
    chk("post_rst_no_held", out_valid, 0);

    // Interlock-only instance stalls on a stage-2 match; forwarding one issues.
    set_stg(2, 1'b1, 1'b0, 5'd5, 32'h77);
    in_valid = 1'b1; in_insn = I_ADDU_6_5_0; in_pc = 32'h200;
    push(I_ADDU_6_5_0, 32'h200, 32'h77, 32'h0, 5'd6, 8'hA0);
    tick();
    chk("f0_stall_valid", f0_out_valid, 0);
    chk("f0_in_ready", f0_in_ready, 0);
    chk("f0_stall_cnt1", f0_stall_cnt, 1);
    chk("f1_issue_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("f0_stall_valid2", f0_out_valid, 0);
    chk("f0_stall_cnt2", f0_stall_cnt, 2);
    set_stg(2, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("f0_issue_valid", f0_out_valid, 1);
    chk("f0_issue_rs", f0_out_rs, rf_val(5'd5));
    chk("f0_issue_insn", f0_out_insn, I_ADDU_6_5_0);
    chk("f0_issue_rd", f0_out_rd, 6);
    chk("f0_stall_cnt_final", f0_stall_cnt, 2);
    chk("f0_in_ready_final", f0_in_ready, 1);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
